// File: rtl/ladybug_rom_loader.sv
`timescale 1ns/1ps
// ladybug_rom_loader
//
// Purpose:
//   Sits between the HPS ioctl download stream and the ladybug core's ROM and
//   PROM memories. The flat MRA stream (index 0) is split into four regions:
//   CPU program, character, sprite and colour/lookup PROM. Each accepted byte
//   produces a one-cycle write strobe with a one-hot region select and a
//   region-local address.
//   The block also captures the game-select byte (index 1) and DIP bank 0
//   (index 254). It keeps a running 16-bit checksum and holds the core in
//   reset until a complete, gap-free ROM set has been loaded.
//
// Ports:
//   clk_sys         system clock (20 MHz)
//   reset_n         asynchronous active-low reset
//   ioctl_download  download in progress
//   ioctl_index     download stream index
//   ioctl_wr        byte-valid strobe, one cycle
//   ioctl_addr      byte address within the stream (25 bits)
//   ioctl_dout      byte data
//   rom_we          region write strobe, one cycle
//   rom_sel         one-hot region select, valid with rom_we
//   rom_addr        region-local address
//   rom_data        write data
//   rom_sum         mod-2^16 sum of all accepted ROM bytes
//   loaded          complete ROM set present
//   load_err        last ROM download failed
//   core_hold       reset request to the core, active high
//   mod             game index byte
//   dip0            DIP bank 0, active-low as delivered

module ladybug_rom_loader #(
    parameter logic [15:0] R0_END = 16'h6000,
    parameter logic [15:0] R1_END = 16'h8000,
    parameter logic [15:0] R2_END = 16'hA000,
    parameter logic [15:0] R3_END = 16'hA060
) (
    input  logic        clk_sys,
    input  logic        reset_n,
    input  logic        ioctl_download,
    input  logic [7:0]  ioctl_index,
    input  logic        ioctl_wr,
    input  logic [24:0] ioctl_addr,
    input  logic [7:0]  ioctl_dout,
    output logic        rom_we,
    output logic [3:0]  rom_sel,
    output logic [15:0] rom_addr,
    output logic [7:0]  rom_data,
    output logic [15:0] rom_sum,
    output logic        loaded,
    output logic        load_err,
    output logic        core_hold,
    output logic [7:0]  mod,
    output logic [7:0]  dip0
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOADING,
        S_DONE,
        S_ERROR
    } state_t;

    state_t      state;
    state_t      state_nxt;

    logic        dl_prev;
    logic [7:0]  idx_lat;
    logic [16:0] cnt;
    logic        gap;
    logic        ovf;

    logic        dl_rise;
    logic        dl_fall;
    logic        enter;
    logic [7:0]  idx_eff;
    logic        load_wr;
    logic        in_range;

    logic [16:0] cnt_nxt;
    logic [15:0] sum_nxt;
    logic        gap_nxt;
    logic        ovf_nxt;
    logic [3:0]  sel_dec;
    logic [15:0] base_dec;

    // Edges of ioctl_download are found against the registered copy.
    // dl_prev resets high, so a download that is already running when reset
    // is released is not seen as a new rising edge. An interrupted load is
    // therefore never resumed.
    assign dl_rise = ioctl_download & ~dl_prev;
    assign dl_fall = ~ioctl_download & dl_prev;

    // The stream index only counts at the rising edge. Later changes while
    // the download stays high are ignored.
    assign idx_eff = dl_rise ? ioctl_index : idx_lat;
    assign enter   = dl_rise && (ioctl_index == 8'd0);

    assign load_wr  = ioctl_download && ioctl_wr && (idx_eff == 8'd0) &&
                      (enter || (state == S_LOADING));
    assign in_range = (ioctl_addr[24:16] == 9'd0) && (ioctl_addr[15:0] < R3_END);

    // Region decode: select one-hot and the region base to subtract.
    always_comb begin
        sel_dec  = 4'b0000;
        base_dec = 16'h0000;
        if (ioctl_addr[15:0] < R0_END) begin
            sel_dec  = 4'b0001;
            base_dec = 16'h0000;
        end else if (ioctl_addr[15:0] < R1_END) begin
            sel_dec  = 4'b0010;
            base_dec = R0_END;
        end else if (ioctl_addr[15:0] < R2_END) begin
            sel_dec  = 4'b0100;
            base_dec = R1_END;
        end else if (ioctl_addr[15:0] < R3_END) begin
            sel_dec  = 4'b1000;
            base_dec = R2_END;
        end
    end

    // Load bookkeeping. On entry to LOADING the counters restart from zero
    // before the strobe of the same cycle is applied. The completion check
    // below therefore always sees the fully updated values.
    always_comb begin
        cnt_nxt = enter ? 17'd0 : cnt;
        sum_nxt = enter ? 16'd0 : rom_sum;
        gap_nxt = enter ? 1'b0  : gap;
        ovf_nxt = enter ? 1'b0  : ovf;
        if (load_wr) begin
            if (ioctl_addr != {8'd0, cnt_nxt}) begin
                gap_nxt = 1'b1;
            end
            if (in_range) begin
                cnt_nxt = cnt_nxt + 17'd1;
                sum_nxt = sum_nxt + {8'd0, ioctl_dout};
            end else begin
                ovf_nxt = 1'b1;
            end
        end
    end

    // Next-state logic and state-derived status outputs.
    always_comb begin
        state_nxt = state;
        loaded    = 1'b0;
        load_err  = 1'b0;
        core_hold = 1'b1;
        case (state)
            S_LOADING: begin
                if (dl_fall) begin
                    if ((cnt_nxt == {1'b0, R3_END}) && !gap_nxt && !ovf_nxt) begin
                        state_nxt = S_DONE;
                    end else begin
                        state_nxt = S_ERROR;
                    end
                end
            end
            S_DONE: begin
                loaded    = 1'b1;
                core_hold = 1'b0;
                if (enter) begin
                    state_nxt = S_LOADING;
                end
            end
            S_ERROR: begin
                load_err = 1'b1;
                if (enter) begin
                    state_nxt = S_LOADING;
                end
            end
            default: begin
                if (enter) begin
                    state_nxt = S_LOADING;
                end
            end
        endcase
    end

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Datapath registers. The write port fields hold their last value between
    // strobes. Only rom_we marks a new write.
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            dl_prev  <= 1'b1;
            idx_lat  <= 8'hFF;
            cnt      <= 17'd0;
            gap      <= 1'b0;
            ovf      <= 1'b0;
            rom_we   <= 1'b0;
            rom_sel  <= 4'b0000;
            rom_addr <= 16'h0000;
            rom_data <= 8'h00;
            rom_sum  <= 16'h0000;
            mod      <= 8'h00;
            dip0     <= 8'hFF;
        end else begin
            dl_prev <= ioctl_download;
            if (dl_rise) begin
                idx_lat <= ioctl_index;
            end
            cnt     <= cnt_nxt;
            gap     <= gap_nxt;
            ovf     <= ovf_nxt;
            rom_sum <= sum_nxt;
            rom_we  <= load_wr && in_range;
            if (load_wr && in_range) begin
                rom_sel  <= sel_dec;
                rom_addr <= ioctl_addr[15:0] - base_dec;
                rom_data <= ioctl_dout;
            end
            if (ioctl_download && ioctl_wr && (ioctl_addr == 25'd0)) begin
                if (idx_eff == 8'd1) begin
                    mod <= ioctl_dout;
                end
                if (idx_eff == 8'd254) begin
                    dip0 <= ioctl_dout;
                end
            end
        end
    end

endmodule

// File: tb/tb_ladybug_rom_loader.sv
`timescale 1ns/1ps
// tb_ladybug_rom_loader
//
// Bench for ladybug_rom_loader. The region map is scaled down by 16 so that
// every load scenario runs in a few thousand cycles. The boundary structure
// matches the real map: three large regions plus a 0x60-byte PROM.
// Expected ROM writes are pushed to a queue when a byte is driven. A monitor
// pops and compares them when rom_we appears.

module tb_ladybug_rom_loader;

    localparam logic [15:0] R0 = 16'h0600;
    localparam logic [15:0] R1 = 16'h0800;
    localparam logic [15:0] R2 = 16'h0A00;
    localparam logic [15:0] R3 = 16'h0A60;

    logic        clk_sys = 1'b0;
    logic        reset_n;
    logic        ioctl_download;
    logic [7:0]  ioctl_index;
    logic        ioctl_wr;
    logic [24:0] ioctl_addr;
    logic [7:0]  ioctl_dout;
    logic        rom_we;
    logic [3:0]  rom_sel;
    logic [15:0] rom_addr;
    logic [7:0]  rom_data;
    logic [15:0] rom_sum;
    logic        loaded;
    logic        load_err;
    logic        core_hold;
    logic [7:0]  mod;
    logic [7:0]  dip0;

    // 20 MHz system clock
    always #25 clk_sys = ~clk_sys;

    ladybug_rom_loader #(
        .R0_END(R0),
        .R1_END(R1),
        .R2_END(R2),
        .R3_END(R3)
    ) dut (
        .clk_sys       (clk_sys),
        .reset_n       (reset_n),
        .ioctl_download(ioctl_download),
        .ioctl_index   (ioctl_index),
        .ioctl_wr      (ioctl_wr),
        .ioctl_addr    (ioctl_addr),
        .ioctl_dout    (ioctl_dout),
        .rom_we        (rom_we),
        .rom_sel       (rom_sel),
        .rom_addr      (rom_addr),
        .rom_data      (rom_data),
        .rom_sum       (rom_sum),
        .loaded        (loaded),
        .load_err      (load_err),
        .core_hold     (core_hold),
        .mod           (mod),
        .dip0          (dip0)
    );

    typedef struct packed {
        logic [3:0]  sel;
        logic [15:0] addr;
        logic [7:0]  data;
    } exp_t;

    typedef struct {
        logic [7:0]  idx;
        logic [24:0] addr;
        logic [7:0]  data;
        bit          dl;
        logic [7:0]  exp_mod;
        logic [7:0]  exp_dip;
    } vec_t;

    exp_t        sb_q[$];
    exp_t        mon_e;
    vec_t        vecs[8];
    int          n_cmp = 0;
    int          n_err = 0;
    int          region_cnt[4];
    bit          model_loading = 1'b0;
    logic [15:0] exp_sum = 16'h0000;

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference region decode for the scaled map
    function automatic logic [3:0] exp_sel(input logic [15:0] a);
        if (a < R0) return 4'b0001;
        if (a < R1) return 4'b0010;
        if (a < R2) return 4'b0100;
        return 4'b1000;
    endfunction

    function automatic logic [15:0] exp_base(input logic [15:0] a);
        if (a < R0) return 16'h0000;
        if (a < R1) return R0;
        if (a < R2) return R1;
        return R2;
    endfunction

    // Each strobe is checked against the scoreboard as it comes out.
    always @(posedge clk_sys) begin
        #1;
        if (rom_we === 1'b1) begin
            if (sb_q.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("[TB] FAIL unexpected_rom_we: got strobe at rom_addr 0x%0h sel %b, expected none",
                         rom_addr, rom_sel);
            end else begin
                mon_e = sb_q.pop_front();
                check_output("rom_sel", 32'(rom_sel), 32'(mon_e.sel));
                check_output("rom_addr", 32'(rom_addr), 32'(mon_e.addr));
                check_output("rom_data", 32'(rom_data), 32'(mon_e.data));
                for (int i = 0; i < 4; i++) begin
                    if (rom_sel[i]) region_cnt[i]++;
                end
            end
        end
    end

    // Drive one byte strobe. The expected write is queued when the DUT should
    // take it.
    task automatic apply_stimulus(input logic [24:0] addr, input logic [7:0] data);
        @(negedge clk_sys);
        ioctl_addr = addr;
        ioctl_dout = data;
        ioctl_wr   = 1'b1;
        if (model_loading && ioctl_download && (addr < {9'd0, R3})) begin
            sb_q.push_back({exp_sel(addr[15:0]), addr[15:0] - exp_base(addr[15:0]), data});
            exp_sum = exp_sum + {8'd0, data};
        end
        @(negedge clk_sys);
        ioctl_wr = 1'b0;
    endtask

    task automatic start_dl(input logic [7:0] idx);
        @(negedge clk_sys);
        ioctl_index    = idx;
        ioctl_download = 1'b1;
        if (idx == 8'd0) begin
            model_loading = 1'b1;
            exp_sum       = 16'h0000;
        end
        @(negedge clk_sys);
    endtask

    task automatic end_dl();
        @(negedge clk_sys);
        ioctl_download = 1'b0;
        model_loading  = 1'b0;
        @(negedge clk_sys);
        @(negedge clk_sys);
    endtask

    // Stream addresses first..last-1 with data = addr[7:0], optionally
    // skipping one address. A probe address is checked right after its strobe.
    task automatic load_stream(input int first, input int last, input int skip,
                               input int probe, input logic [15:0] probe_addr,
                               input logic [3:0] probe_sel);
        for (int a = first; a < last; a++) begin
            if (a != skip) begin
                apply_stimulus(25'(a), 8'(a));
                if (a == probe) begin
                    check_output("probe_rom_we", 32'(rom_we), 32'd1);
                    check_output("probe_rom_addr", 32'(rom_addr), 32'(probe_addr));
                    check_output("probe_rom_sel", 32'(rom_sel), 32'(probe_sel));
                end
            end
        end
    endtask

    task automatic check_status(input string tag, input logic exp_loaded,
                                input logic exp_err, input logic exp_hold);
        check_output({tag, "_loaded"}, 32'(loaded), 32'(exp_loaded));
        check_output({tag, "_load_err"}, 32'(load_err), 32'(exp_err));
        check_output({tag, "_core_hold"}, 32'(core_hold), 32'(exp_hold));
        check_output({tag, "_rom_sum"}, 32'(rom_sum), 32'(exp_sum));
        check_output({tag, "_sb_empty"}, 32'(sb_q.size()), 32'd0);
    endtask

    task automatic check_reset_values(input string tag);
        check_output({tag, "_rom_we"}, 32'(rom_we), 32'd0);
        check_output({tag, "_rom_sel"}, 32'(rom_sel), 32'd0);
        check_output({tag, "_rom_addr"}, 32'(rom_addr), 32'd0);
        check_output({tag, "_rom_data"}, 32'(rom_data), 32'd0);
        check_output({tag, "_rom_sum"}, 32'(rom_sum), 32'd0);
        check_output({tag, "_loaded"}, 32'(loaded), 32'd0);
        check_output({tag, "_load_err"}, 32'(load_err), 32'd0);
        check_output({tag, "_core_hold"}, 32'(core_hold), 32'd1);
        check_output({tag, "_mod"}, 32'(mod), 32'h00);
        check_output({tag, "_dip0"}, 32'(dip0), 32'hFF);
    endtask

    // Watchdog: the scenario list is fixed-length, so this only fires on a hang.
    initial begin
        #5_000_000;
        $display("[TB] FAIL watchdog: got no completion, expected summary before 5 ms");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        // Sideband writes applied while a complete ROM set is loaded
        vecs[0] = '{8'd1,   25'd0, 8'h02, 1'b1, 8'h02, 8'hFF};
        vecs[1] = '{8'd254, 25'd0, 8'h7F, 1'b1, 8'h02, 8'h7F};
        vecs[2] = '{8'd254, 25'd3, 8'h00, 1'b1, 8'h02, 8'h7F};
        vecs[3] = '{8'd1,   25'd1, 8'h55, 1'b1, 8'h02, 8'h7F};
        vecs[4] = '{8'd7,   25'd0, 8'hAA, 1'b1, 8'h02, 8'h7F};
        vecs[5] = '{8'd1,   25'd0, 8'hC3, 1'b0, 8'h02, 8'h7F};
        vecs[6] = '{8'd0,   25'd5, 8'h11, 1'b0, 8'h02, 8'h7F};
        vecs[7] = '{8'd254, 25'd0, 8'h3C, 1'b1, 8'h02, 8'h3C};

        reset_n        = 1'b1;
        ioctl_download = 1'b0;
        ioctl_index    = 8'd0;
        ioctl_wr       = 1'b0;
        ioctl_addr     = 25'd0;
        ioctl_dout     = 8'd0;
        #10 reset_n = 1'b0;
        repeat (3) @(negedge clk_sys);
        check_reset_values("reset");
        reset_n = 1'b1;
        repeat (2) @(negedge clk_sys);
        check_output("idle_core_hold", 32'(core_hold), 32'd1);

        $display("[TB] full load");
        for (int i = 0; i < 4; i++) region_cnt[i] = 0;
        start_dl(8'd0);
        load_stream(0, int'(R3), -1, int'(R1) + 5, 16'h0005, 4'b0100);
        check_output("loading_core_hold", 32'(core_hold), 32'd1);
        end_dl();
        check_status("full", 1'b1, 1'b0, 1'b0);
        check_output("count_region0", 32'(region_cnt[0]), 32'(R0));
        check_output("count_region1", 32'(region_cnt[1]), 32'(R1 - R0));
        check_output("count_region2", 32'(region_cnt[2]), 32'(R2 - R1));
        check_output("count_region3", 32'(region_cnt[3]), 32'(R3 - R2));

        $display("[TB] sideband capture table");
        for (int v = 0; v < 8; v++) begin
            if (vecs[v].dl) begin
                start_dl(vecs[v].idx);
            end else begin
                @(negedge clk_sys);
                ioctl_index = vecs[v].idx;
            end
            apply_stimulus(vecs[v].addr, vecs[v].data);
            if (vecs[v].dl) end_dl();
            repeat (2) @(negedge clk_sys);
            check_output($sformatf("vec%0d_mod", v), 32'(mod), 32'(vecs[v].exp_mod));
            check_output($sformatf("vec%0d_dip0", v), 32'(dip0), 32'(vecs[v].exp_dip));
            check_status($sformatf("vec%0d", v), 1'b1, 1'b0, 1'b0);
        end

        // The index is latched at the rising edge. A later change to 0 must
        // not turn an index-1 download into a ROM load.
        start_dl(8'd1);
        ioctl_index = 8'd0;
        apply_stimulus(25'd0, 8'h99);
        end_dl();
        check_output("latched_idx_mod", 32'(mod), 32'h99);
        check_status("latched_idx", 1'b1, 1'b0, 1'b0);

        $display("[TB] reload then short load");
        @(negedge clk_sys);
        ioctl_index    = 8'd0;
        ioctl_download = 1'b1;
        model_loading  = 1'b1;
        exp_sum        = 16'h0000;
        @(negedge clk_sys);
        check_output("reload_core_hold", 32'(core_hold), 32'd1);
        check_output("reload_loaded", 32'(loaded), 32'd0);
        check_output("reload_rom_sum", 32'(rom_sum), 32'd0);
        load_stream(0, int'(R3) - 1, -1, -1, 16'h0000, 4'b0000);
        end_dl();
        check_status("short", 1'b0, 1'b1, 1'b1);

        $display("[TB] gap load");
        start_dl(8'd0);
        load_stream(0, int'(R3), 'h234, 'h235, 16'h0235, 4'b0001);
        end_dl();
        check_status("gap", 1'b0, 1'b1, 1'b1);

        $display("[TB] overflow load");
        start_dl(8'd0);
        load_stream(0, int'(R3), -1, -1, 16'h0000, 4'b0000);
        apply_stimulus({9'd0, R3}, 8'h5A);
        apply_stimulus(25'h10005, 8'hA5);
        end_dl();
        check_status("overflow", 1'b0, 1'b1, 1'b1);

        $display("[TB] async reset mid-load");
        start_dl(8'd0);
        load_stream(0, 'h300, -1, -1, 16'h0000, 4'b0000);
        #2 reset_n = 1'b0;
        #1;
        check_reset_values("midload_reset");
        sb_q.delete();
        model_loading = 1'b0;
        exp_sum       = 16'h0000;
        @(negedge clk_sys);
        reset_n = 1'b1;
        repeat (3) @(negedge clk_sys);
        apply_stimulus(25'h300, 8'h00);
        check_status("after_reset", 1'b0, 1'b0, 1'b1);
        end_dl();

        start_dl(8'd0);
        load_stream(0, int'(R3), -1, int'(R3) - 1, 16'h005F, 4'b1000);
        end_dl();
        check_status("final_full", 1'b1, 1'b0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
